// File: rtl/mul_arb_pkg.sv
// Shared definitions for the two-requester sequential multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int MUL_W = 32;
  localparam int N_REQ = 2;

endpackage

// File: rtl/mul_shift_add_core.sv
// Shift-add unsigned multiplier datapath: one partial product per step,
// W steps per operation, no early exit.
module mul_shift_add_core
  import mul_arb_pkg::*;
#(
  parameter int W     = MUL_W,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   op1,
  input  logic [W-1:0]   op2,
  input  logic           step,
  output logic [2*W-1:0] acc,
  output logic           last
);

  logic [2*W-1:0] a_q, a_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      a_d   = {{W{1'b0}}, op1};
      b_d   = op2;
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      // The accumulator is 2*W wide, so the running sum can never overflow.
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/mul32u_arb.sv
// Round-robin arbiter and controller sharing one shift-add multiplier
// between two requesters with valid/ready request and response channels.
module mul32u_arb
  import mul_arb_pkg::*;
#(
  parameter int W     = MUL_W,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_op1,
  input  logic [N_REQ*W-1:0]   req_op2,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [2*W-1:0]       rsp_data,
  output logic                 busy
);

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_grant_q, last_grant_d;
  logic           grant;
  logic           grant_any;
  logic           accept;
  logic           step;
  logic           last;
  logic [W-1:0]   op1_sel;
  logic [W-1:0]   op2_sel;
  logic [2*W-1:0] acc;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_any = 1'b0;
    grant     = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_any = 1'b1;
        grant     = 1'b0;
      end
      2'b10: begin
        grant_any = 1'b1;
        grant     = 1'b1;
      end
      2'b11: begin
        grant_any = 1'b1;
        grant     = ~last_grant_q;
      end
      default: begin
        grant_any = 1'b0;
        grant     = 1'b0;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grant_any) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept  = (state_q == IDLE) && grant_any;
  assign op1_sel = req_op1[int'(grant)*W +: W];
  assign op2_sel = req_op2[int'(grant)*W +: W];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    step         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = CALC;
          owner_d      = grant;
          last_grant_d = grant;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  mul_shift_add_core #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .op1  (op1_sel),
    .op2  (op2_sel),
    .step (step),
    .acc  (acc),
    .last (last)
  );

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
      rsp_data           = acc;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mul32u_arb.sv
// Self-checking bench for mul32u_arb: vector table plus hand-written
// tie, fairness, backpressure and reset sequences, checked by a scoreboard.
module tb_mul32u_arb;
  import mul_arb_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic           req;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic [2*W-1:0] exp;
  } vec_t;

  typedef struct {
    logic           req;
    logic [2*W-1:0] data;
  } sb_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_op1;
  logic [2*W-1:0] req_op2;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic           busy;

  int   total = 0;
  int   bad = 0;
  sb_t  sb[$];
  sb_t  sb_head;
  int   acc_cnt[2] = '{0, 0};
  int   grant_log[$];
  int   cyc = 0;
  int   last_accept_cyc = -1000;
  logic [1:0]     prev_valid = '0;
  logic [2*W-1:0] prev_data = '0;
  logic           prev_hs = 1'b0;
  logic           prev_stall = 1'b0;

  vec_t vecs[8];

  mul32u_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [W-1:0] op1, input logic [W-1:0] op2);
    req_op1[i*W +: W] = op1;
    req_op2[i*W +: W] = op2;
  endtask

  task automatic expect_rsp(input logic req, input logic [2*W-1:0] data);
    sb_t e;
    e.req  = req;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: samples 2 ns after each falling edge, i.e. on the values the
  // next rising edge will see.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      sb.delete();
      prev_valid      = '0;
      prev_hs         = 1'b0;
      prev_stall      = 1'b0;
      last_accept_cyc = -1000;
    end else begin
      if (prev_hs) begin
        checkOutput("idle_after_rsp_busy", 64'(busy), 64'd0);
        checkOutput("idle_after_rsp_valid", 64'(rsp_valid), 64'd0);
      end
      if (prev_stall) begin
        checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'(prev_valid));
        checkOutput("stall_rsp_data", rsp_data, prev_data);
      end
      if (rsp_valid == 2'b00) begin
        checkOutput("rsp_data_zero", rsp_data, 64'd0);
      end else begin
        checkOutput("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
        if (prev_valid == 2'b00) begin
          checkOutput("latency", 64'(cyc - last_accept_cyc), 64'(W + 1));
        end
      end
      if (busy) begin
        checkOutput("ready_low_when_busy", 64'(req_ready), 64'd0);
      end
      checkOutput("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      prev_hs    = (rsp_valid & rsp_ready) != 2'b00;
      prev_stall = (rsp_valid != 2'b00) && !prev_hs;
      if (prev_hs) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          sb_head = sb.pop_front();
          checkOutput("rsp_owner", 64'(rsp_valid), sb_head.req ? 64'd2 : 64'd1);
          checkOutput("rsp_data", rsp_data, sb_head.data);
        end
      end
      prev_valid = rsp_valid;
      prev_data  = rsp_data;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          checkOutput("accept_spacing", 64'((cyc - last_accept_cyc) >= W + 2), 64'd1);
          last_accept_cyc = cyc;
          acc_cnt[i]++;
          grant_log.push_back(i);
        end
      end
    end
  end

  // Holds each requester valid until it has been accepted the requested
  // number of extra times, then waits for all responses to drain.
  task automatic run_ops(input int n0, input int n1, input string name);
    int t0;
    int t1;
    int k;
    int lim;
    t0  = acc_cnt[0] + n0;
    t1  = acc_cnt[1] + n1;
    lim = 40 * (n0 + n1) + 50;
    k   = 0;
    while (k < lim) begin
      @(negedge clk);
      req_valid[0] = acc_cnt[0] < t0;
      req_valid[1] = acc_cnt[1] < t1;
      if (acc_cnt[0] >= t0 && acc_cnt[1] >= t1 && sb.size() == 0 && !busy) break;
      k++;
    end
    req_valid = '0;
    checkOutput({name, "_timeout"}, 64'(k >= lim), 64'd0);
  endtask

  task automatic wait_accept(input int i, input int target, input string name);
    int k;
    k = 0;
    while (acc_cnt[i] < target && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_accept_timeout"}, 64'(k >= 100), 64'd0);
  endtask

  task automatic wait_rsp(input string name);
    int k;
    k = 0;
    while (rsp_valid == 2'b00 && k < 60) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_rsp_timeout"}, 64'(k >= 60), 64'd0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_idle_timeout"}, 64'(k >= 100), 64'd0);
  endtask

  task automatic check_grants(input int base, input int first, input int n, input string name);
    for (int j = 0; j < n; j++) begin
      if (base + j < grant_log.size()) begin
        checkOutput(name, 64'(grant_log[base + j]), 64'(first ^ (j % 2)));
      end else begin
        checkOutput({name, "_missing"}, 64'(grant_log.size()), 64'(base + n));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int first;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{1'b0, 32'd3, 32'd5, 64'd15};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'd0, 64'd0};
    vecs[3] = '{1'b0, 32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000};
    for (int i = 5; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      vecs[i] = '{1'(i % 2), ra, rb, {32'd0, ra} * {32'd0, rb}};
    end

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 2'b11;
    req_op1   = '0;
    req_op2   = '0;
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_data", rsp_data, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Tie straight after reset: requester 0 first, then requester 1.
    applyStimulus(0, 32'd7, 32'd9);
    applyStimulus(1, 32'h0001_0000, 32'h0001_0000);
    expect_rsp(1'b0, 64'd63);
    expect_rsp(1'b1, 64'h0000_0001_0000_0000);
    base = grant_log.size();
    run_ops(1, 1, "tie_after_reset");
    check_grants(base, 0, 2, "tie_after_reset_grant");

    foreach (vecs[i]) begin
      applyStimulus(int'(vecs[i].req), vecs[i].op1, vecs[i].op2);
      applyStimulus(int'(~vecs[i].req), 32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i));
      expect_rsp(vecs[i].req, vecs[i].exp);
      run_ops(vecs[i].req ? 0 : 1, vecs[i].req ? 1 : 0, "vector");
    end

    // Both requesters held valid: grants must alternate.
    first = 1 - grant_log[grant_log.size() - 1];
    applyStimulus(0, 32'd1000, 32'd3000);
    applyStimulus(1, 32'h1234_5678, 32'd16);
    for (int j = 0; j < 6; j++) begin
      if ((first ^ (j % 2)) == 0) expect_rsp(1'b0, 64'd3000000);
      else expect_rsp(1'b1, 64'h0000_0001_2345_6780);
    end
    base = grant_log.size();
    run_ops(3, 3, "fairness");
    check_grants(base, first, 6, "fairness_grant");

    // Response held off for 20 cycles; the other requester's ready is ignored.
    applyStimulus(0, 32'd123, 32'd456);
    expect_rsp(1'b0, 64'd56088);
    @(negedge clk);
    rsp_ready = 2'b10;
    req_valid = 2'b01;
    wait_accept(0, acc_cnt[0] + 1, "backpressure");
    req_valid = '0;
    wait_rsp("backpressure");
    repeat (20) @(negedge clk);
    checkOutput("backpressure_valid_held", 64'(rsp_valid), 64'd1);
    checkOutput("backpressure_data_held", rsp_data, 64'd56088);
    rsp_ready = 2'b01;
    wait_idle("backpressure");
    rsp_ready = 2'b11;

    // Reset in the middle of a requester-0 multiply.
    applyStimulus(0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    expect_rsp(1'b0, {32'd0, 32'hDEAD_BEEF} * {32'd0, 32'h0BAD_F00D});
    @(negedge clk);
    req_valid = 2'b01;
    wait_accept(0, acc_cnt[0] + 1, "reset_mid");
    req_valid = '0;
    repeat (10) @(negedge clk);
    checkOutput("reset_mid_busy_before", 64'(busy), 64'd1);
    req_valid = 2'b11;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_busy", 64'(busy), 64'd0);
    checkOutput("reset_mid_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_mid_rsp_data", rsp_data, 64'd0);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_mid_no_rsp", 64'(rsp_valid), 64'd0);

    applyStimulus(0, 32'd11, 32'd13);
    applyStimulus(1, 32'd17, 32'd19);
    expect_rsp(1'b0, 64'd143);
    expect_rsp(1'b1, 64'd323);
    base = grant_log.size();
    run_ops(1, 1, "tie_after_midreset");
    check_grants(base, 0, 2, "tie_after_midreset_grant");

    applyStimulus(1, 32'd100, 32'd200);
    expect_rsp(1'b1, 64'd20000);
    base = grant_log.size();
    run_ops(0, 1, "req1_only");
    check_grants(base, 1, 1, "req1_only_grant");

    applyStimulus(0, 32'd21, 32'd2);
    applyStimulus(1, 32'd5, 32'd5);
    expect_rsp(1'b0, 64'd42);
    expect_rsp(1'b1, 64'd25);
    base = grant_log.size();
    run_ops(1, 1, "tie_after_req1");
    check_grants(base, 0, 2, "tie_after_req1_grant");

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul32u_arb.md
Name: mul32u_arb

Overview:
- Controller and arbiter that shares one sequential shift-add unsigned multiplier between two requesters.
- Accepts an operand pair from the granted requester and runs a fixed 32-iteration multiply.
- Returns the 64-bit product to that requester on a valid/ready response channel.
- Sits between the integer execution units and the multiplier datapath.

Parameters:
- W, 32, operand width; product width is 2*W; iteration count is W.
- CNT_W, $clog2(W)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- req_valid  in  2  per-requester operand valid.
- req_ready  out  2  per-requester accept.
- req_op1  in  2*W  packed multiplicands; requester i uses bits [i*W +: W].
- req_op2  in  2*W  packed multipliers; same packing as req_op1.
- rsp_valid  out  2  product valid for requester i; one-hot or zero.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  2*W  shared product bus, valid when any rsp_valid bit is high.
- busy  out  1  high in any state other than IDLE.

Interface decision: one clock (clk); reset (rst) is asynchronous and active-high.

Behaviour:
- States:
  - IDLE: wait for a request.
  - CALC: W cycles of shift-add.
  - RESP: hold the result until the owner takes it.
- Reset (async, active-high), effective immediately:
  - state=IDLE; acc=0; a_reg=0; b_reg=0; cnt=0; owner=0; last_grant=1.
  - Outputs: req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
- Reset mid-CALC or mid-RESP: operation is silently dropped; no rsp_valid is ever produced for it.
- Grant, combinational, IDLE only:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the one that is not last_grant. After reset, requester 0 wins the first tie.
  - req_ready[i] = (state==IDLE) && grant==i && req_valid[i].
  - req_ready is never high outside IDLE.
- Accept, at a cycle where req_valid[i] && req_ready[i]:
  - Latch a_reg=req_op1[i] zero-extended to 2*W, b_reg=req_op2[i].
  - acc=0, cnt=0, owner=i, last_grant=i.
  - Next state CALC.
- CALC, each cycle:
  - acc <= acc + (b_reg[0] ? a_reg : 0), computed 2*W wide with no overflow possible.
  - a_reg <= a_reg << 1; b_reg <= b_reg >> 1; cnt <= cnt + 1.
  - When cnt==W-1, go to RESP.
- Latency and throughput:
  - Fixed latency regardless of operand values; there is no early exit when b_reg becomes 0.
  - Accept at edge t; CALC occupies edges t+1..t+W; rsp_valid[owner] is high from t+W onward, i.e. W cycles after accept.
- RESP:
  - rsp_valid[owner]=1 and rsp_data=acc, both stable until rsp_ready[owner]=1.
  - On that handshake: next state IDLE, rsp_valid drops the next cycle.
  - rsp_ready of the non-owner is ignored.
  - No new accept in the same cycle as a response handshake, so minimum spacing is W+2 cycles per operation.
- req_valid may drop at any time before accept; no state is retained for withdrawn requests.
- rsp_data reads 0 in IDLE and CALC.

Decomposition:
- Shared package mul_arb_pkg holds:
  - the state encoding (IDLE=2'd0, CALC=2'd1, RESP=2'd2);
  - default W=32;
  - N_REQ=2.
- Sub-module mul_shift_add_core holds the datapath: a_reg, b_reg, acc, cnt.
  - Inputs: clk, rst, load, op1, op2, step.
  - Outputs: acc, last (cnt==W-1).
- mul32u_arb keeps the FSM, grant logic, owner/last_grant registers and port muxing.

Test Plan:
1. Single op: req0 op1=3, op2=5 → accepted at edge t; rsp_valid=2'b01 at t+32 with rsp_data=15; req_ready=0 throughout CALC and RESP.
2. Maximum operands: req1 op1=op2=0xFFFFFFFF → rsp_data=0xFFFFFFFE00000001 on rsp_valid=2'b10. Second run with op2=0 → rsp_data=0, still exactly 32 cycles of latency.
3. Tie after reset: both valid, req0 (7×9) and req1 (0x10000×0x10000) → req0 served first with 63; then req1 with 0x0000000100000000; order verified by rsp_valid one-hot sequence.
4. Round-robin fairness: both requesters held valid continuously for 6 operations → grants alternate 0,1,0,1,0,1; each accept spaced ≥34 cycles apart.
5. Backpressure: rsp_ready[0] held low for 20 cycles in RESP → rsp_valid and rsp_data stable for all 20 cycles; asserting rsp_ready[1] meanwhile has no effect; release → IDLE next cycle.
6. Reset mid-operation: assert rst at CALC cycle 10 → outputs 0 immediately (asynchronous); no response ever appears; after release, a req1-only request is accepted, and a following tie grants req0 (last_grant reset to 1).
